instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage between the program ROM and the CPU controller.
- Takes the 6-bit program counter and fetch request from the controller.
- Drives a synchronous fixed-latency ROM.
- Returns the 16-bit instruction word with a valid/stall handshake.
- Holds a two-entry line buffer (current, next) with sequential prefetch, so straight-line code hits without ROM latency and branches cost one ROM round-trip.

Parameters:
- ADDR_W, 6, program address width (matches controller PC).
- DATA_W, 16, instruction width.
- ROM_LAT, 1, cycles from a rom_en cycle to valid rom_data; legal range 1..4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  ADDR_W  instruction address requested by controller.
- fetch_req  input  1  controller requests instruction at pc_in this cycle.
- inv  input  1  invalidate both buffer entries and any in-flight read.
- rom_addr  output  ADDR_W  ROM read address, registered.
- rom_en  output  1  ROM read strobe, one-cycle pulse per issued read, registered.
- rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after the rom_en cycle.
- instr_out  output  DATA_W  instruction word to controller (its ROM_data input).
- instr_valid  output  1  instr_out is the word at pc_in this cycle.
- stall  output  1  fetch_req active and not yet served; controller must hold pc_in and state.

Behaviour:
- Reset (reset=0, asynchronous):
  - CUR and NXT entries invalid; FSM in IDLE; latency counter 0.
  - rom_en=0, rom_addr=0.
  - instr_out=0, instr_valid=0, stall=0.
- Entries: CUR and NXT, each {addr[ADDR_W], data[DATA_W], valid}.
- Hit path is combinational from registered entries:
  - CUR.valid and pc_in==CUR.addr: instr_out=CUR.data, instr_valid=1.
  - Otherwise NXT.valid and pc_in==NXT.addr: instr_out=NXT.data, instr_valid=1.
  - Otherwise instr_valid=0, instr_out holds its last registered value.
  - stall = fetch_req & ~instr_valid.
  - Without fetch_req, instr_valid still reflects the lookup and no state changes are caused by the lookup.
- NXT hit with fetch_req: at the next edge, NXT is promoted to CUR, NXT is invalidated, and a prefetch of pc_in+1 is issued.
- FSM states: IDLE, DEMAND, PREF.
- IDLE:
  - On fetch_req and miss: issue read at pc_in (rom_en=1, rom_addr=pc_in next cycle), go to DEMAND.
  - Otherwise, if CUR.valid and NXT is invalid: issue prefetch at CUR.addr+1, go to PREF.
- DEMAND:
  - Counter runs ROM_LAT cycles after the issue cycle, then captures rom_data into CUR {rom_addr, data, 1} and invalidates NXT.
  - instr_valid goes high the following cycle (hit on CUR).
  - Returns to IDLE, which immediately launches the prefetch of addr+1.
  - Cold miss: request at cycle t, instr_valid at t+ROM_LAT+2.
- PREF:
  - On completion, captures into NXT and goes to IDLE.
  - If fetch_req misses during PREF and pc_in equals the prefetch address: convert to DEMAND without reissuing, completing at the original time and writing CUR.
  - If fetch_req misses during PREF and pc_in differs: abort, reissue at pc_in on the next cycle, restart the counter, go to DEMAND. Data for the aborted read is never captured.
- Address arithmetic: addr+1 is modulo 2^ADDR_W; 63 wraps to 0 (prefetch of 0 after 63).
- Only one read is outstanding; captures are accepted only at counter==ROM_LAT of the latest issue.
- inv=1:
  - At the edge, both entries are invalidated and any in-flight read is abandoned; FSM goes to IDLE.
  - inv has priority over a capture in the same cycle.
  - instr_valid=0 in the cycle inv is sampled high.
- Reset asserted mid-DEMAND/PREF: immediate return to the reset state; no capture after deassertion.
- Simultaneous CUR and NXT address match is impossible by construction (NXT.addr = CUR.addr+1). CUR wins regardless.

Test Plan:
- Cold fetch: ROM_LAT=1, reset then pc_in=5, fetch_req=1 at cycle 0. Required: rom_en with rom_addr=5 at cycle 1; instr_valid=1 with ROM[5] at cycle 3; stall=1 at cycles 0-2; prefetch rom_addr=6 issued next.
- Sequential run: pc 5,6,7 each held until valid. Required: after the first miss, pc=6 is valid with no stall once the prefetch lands; each promotion issues the next prefetch; ROM[6], ROM[7] are correct.
- Branch during prefetch: PREF of 6 in flight, pc_in=20 requested. Required: rom_addr=20 reissued next cycle; ROM[6] is never presented; instr_out=ROM[20].
- Demand equals prefetch address: PREF of 6 in flight, pc_in=6 requested. Required: no second rom_en; valid at the original completion+1.
- Wrap: fetch pc=63. Required: prefetch rom_addr=0; pc_in=0 then hits with ROM[0].
- Reset and invalidate:
  - reset low mid-DEMAND (ROM_LAT=3). Required: all outputs 0 immediately, no late capture.
  - inv pulse with CUR valid. Required: next fetch of the same pc misses and re-reads the ROM.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: two-entry line buffer (CUR/NXT) in front of a fixed-latency ROM,
// with sequential prefetch and a valid/stall handshake toward the controller.
module instr_fetch_unit #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_req,
    input  logic              inv,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              stall,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEMAND = 2'd1,
        PREF   = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   cur_addr, nxt_addr;
    logic [DATA_W-1:0]   cur_data, nxt_data, last_out;
    logic                cur_valid, nxt_valid;

    logic                cur_hit, nxt_hit, hit, miss, cap;
    logic [DATA_W-1:0]   hit_data;

    // Handshake: instr_valid means instr_out is the word at pc_in this cycle; while
    // fetch_req is high and instr_valid is low, stall is high and the controller holds pc_in.
    always_comb begin
        cur_hit     = cur_valid && (pc_in == cur_addr);
        nxt_hit     = nxt_valid && (pc_in == nxt_addr) && !cur_hit;
        hit         = cur_hit || nxt_hit;
        hit_data    = cur_hit ? cur_data : nxt_data;
        instr_valid = hit && !inv;
        instr_out   = instr_valid ? hit_data : last_out;
        stall       = fetch_req && !instr_valid && reset;
        miss        = fetch_req && !hit;
        cap         = (cnt == CNT_W'(ROM_LAT));
        fsm_state   = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            cur_valid <= 1'b0;
            nxt_addr  <= '0;
            nxt_data  <= '0;
            nxt_valid <= 1'b0;
            last_out  <= '0;
        end else begin
            rom_en   <= 1'b0;
            last_out <= instr_out;
            if (inv) begin
                cur_valid <= 1'b0;
                nxt_valid <= 1'b0;
                cnt       <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (miss) begin
                            rom_en   <= 1'b1;
                            rom_addr <= pc_in;
                            cnt      <= '0;
                            state    <= DEMAND;
                        end else if (fetch_req && nxt_hit) begin
                            cur_addr  <= nxt_addr;
                            cur_data  <= nxt_data;
                            cur_valid <= 1'b1;
                            nxt_valid <= 1'b0;
                            rom_en    <= 1'b1;
                            rom_addr  <= nxt_addr + ADDR_W'(1);
                            cnt       <= '0;
                            state     <= PREF;
                        end else if (cur_valid && !nxt_valid) begin
                            rom_en   <= 1'b1;
                            rom_addr <= cur_addr + ADDR_W'(1);
                            cnt      <= '0;
                            state    <= PREF;
                        end
                    end
                    DEMAND: begin
                        if (cap) begin
                            cur_addr  <= rom_addr;
                            cur_data  <= rom_data;
                            cur_valid <= 1'b1;
                            nxt_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PREF: begin
                        if (miss && (pc_in != rom_addr)) begin
                            // Branch away from the prefetch: the old read's data is never captured.
                            rom_en   <= 1'b1;
                            rom_addr <= pc_in;
                            cnt      <= '0;
                            state    <= DEMAND;
                        end else if (cap) begin
                            if (miss) begin
                                cur_addr  <= rom_addr;
                                cur_data  <= rom_data;
                                cur_valid <= 1'b1;
                                nxt_valid <= 1'b0;
                            end else begin
                                nxt_addr  <= rom_addr;
                                nxt_data  <= rom_data;
                                nxt_valid <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (miss) state <= DEMAND;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
